// File: rtl/mem_arbiter.sv
// Multi-channel memory arbiter: selects one requester, owns the memory
// port until mem_resp, then routes the completion back to that channel.
module mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RR_MODE    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_read,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] req_byte_enable,
    output logic [NUM_PORTS-1:0]            req_resp,
    output logic [DATA_WIDTH-1:0]           req_rdata,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic [DATA_WIDTH/8-1:0]         mem_byte_enable,
    input  logic                            mem_resp,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
    output logic                            busy
);

    localparam int GW = $clog2(NUM_PORTS);
    localparam int BW = DATA_WIDTH / 8;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [NUM_PORTS-1:0] req_any;
    logic                 found;
    logic [GW-1:0]        win;
    logic [GW-1:0]        rr_ptr;
    int                   idx;
    logic                 take;
    logic                 done;

    assign req_any = req_read | req_write;
    assign take    = (state == IDLE) && found;
    assign done    = (state == BUSY) && mem_resp;

    // Pick the winning channel, scanning from the RR pointer or from index 0
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (RR_MODE != 0)
                idx = (int'(rr_ptr) + k) % NUM_PORTS;
            else
                idx = k;
            if (!found && req_any[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: leave IDLE on any request, leave BUSY on completion
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (found)    state_nxt = BUSY;
            BUSY: if (mem_resp) state_nxt = IDLE;
        endcase
    end

    // Capture the granted channel's request; strobes drop after completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            grant_id        <= '0;
            rr_ptr          <= '0;
        end else if (take) begin
            mem_write       <= req_write[win];
            mem_read        <= req_read[win] & ~req_write[win];
            mem_address     <= req_address[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata       <= req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            mem_byte_enable <= req_byte_enable[int'(win)*BW +: BW];
            grant_id        <= win;
            if (RR_MODE != 0)
                rr_ptr <= GW'((int'(win) + 1) % NUM_PORTS);
        end else if (done) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    // Completion routing: pulse only the owner, zero data otherwise
    always_comb begin
        req_resp  = '0;
        req_rdata = '0;
        busy      = (state == BUSY);
        if (done) begin
            req_resp[grant_id] = 1'b1;
            req_rdata          = mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-port round-robin instance and a
// 4-port fixed-priority instance sharing clock and reset.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: 2 ports, round-robin
    logic [1:0]  a_rd = '0, a_wr = '0;
    logic [63:0] a_addr = {32'h200, 32'h100};
    logic [63:0] a_wdata = {32'hA5A5A5A5, 32'hC0FFEE00};
    logic [7:0]  a_be = {4'b1100, 4'b0001};
    logic [1:0]  a_resp;
    logic [31:0] a_rdata, a_maddr, a_mwd, a_mrdata = '0;
    logic        a_mrd, a_mwr, a_mresp = 1'b0, a_busy;
    logic [3:0]  a_mbe;
    logic [0:0]  a_gid;

    // Instance B: 4 ports, fixed priority
    logic [3:0]   b_rd = '0, b_wr = '0;
    logic [127:0] b_addr = {32'h3000, 32'h40, 32'h2000, 32'h1000};
    logic [127:0] b_wdata = {32'h33333333, 32'h12345678, 32'h11111111, 32'h0};
    logic [15:0]  b_be = {4'b1111, 4'b0011, 4'b1000, 4'b0100};
    logic [3:0]   b_resp;
    logic [31:0]  b_rdata, b_maddr, b_mwd, b_mrdata = '0;
    logic         b_mrd, b_mwr, b_mresp = 1'b0, b_busy;
    logic [3:0]   b_mbe;
    logic [1:0]   b_gid;

    mem_arbiter #(.NUM_PORTS(2), .RR_MODE(1)) u_a (
        .clk(clk), .rst(rst),
        .req_read(a_rd), .req_write(a_wr),
        .req_address(a_addr), .req_wdata(a_wdata),
        .req_byte_enable(a_be),
        .req_resp(a_resp), .req_rdata(a_rdata),
        .mem_read(a_mrd), .mem_write(a_mwr),
        .mem_address(a_maddr), .mem_wdata(a_mwd),
        .mem_byte_enable(a_mbe),
        .mem_resp(a_mresp), .mem_rdata(a_mrdata),
        .grant_id(a_gid), .busy(a_busy)
    );

    mem_arbiter #(.NUM_PORTS(4), .RR_MODE(0)) u_b (
        .clk(clk), .rst(rst),
        .req_read(b_rd), .req_write(b_wr),
        .req_address(b_addr), .req_wdata(b_wdata),
        .req_byte_enable(b_be),
        .req_resp(b_resp), .req_rdata(b_rdata),
        .mem_read(b_mrd), .mem_write(b_mwr),
        .mem_address(b_maddr), .mem_wdata(b_mwd),
        .mem_byte_enable(b_mbe),
        .mem_resp(b_mresp), .mem_rdata(b_mrdata),
        .grant_id(b_gid), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [31:0] rdata;
        logic [31:0] gid;
        logic        mrd;
        logic        mwr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Round-robin pointer starts at 0 and moves to grant+1 on each grant
        vecs[0] = '{2'b01, 2'b00, 32'hDEADBEEF, 0, 1, 0, 32'h100, 32'hC0FFEE00, 4'b0001};
        vecs[1] = '{2'b00, 2'b10, 32'h11111111, 1, 0, 1, 32'h200, 32'hA5A5A5A5, 4'b1100};
        vecs[2] = '{2'b11, 2'b00, 32'h22222222, 0, 1, 0, 32'h100, 32'hC0FFEE00, 4'b0001};
        vecs[3] = '{2'b11, 2'b00, 32'h33333333, 1, 1, 0, 32'h200, 32'hA5A5A5A5, 4'b1100};
        vecs[4] = '{2'b10, 2'b10, 32'h44444444, 1, 0, 1, 32'h200, 32'hA5A5A5A5, 4'b1100};
        vecs[5] = '{2'b01, 2'b10, 32'h55555555, 0, 1, 0, 32'h100, 32'hC0FFEE00, 4'b0001};
        vecs[6] = '{2'b01, 2'b00, 32'h66666666, 0, 1, 0, 32'h100, 32'hC0FFEE00, 4'b0001};
        vecs[7] = '{2'b00, 2'b11, 32'h77777777, 1, 0, 1, 32'h200, 32'hA5A5A5A5, 4'b1100};

        // Reset state
        #1;
        chk("rst_a_busy", 32'(a_busy), 0);
        chk("rst_a_mrd", 32'(a_mrd), 0);
        chk("rst_a_mwr", 32'(a_mwr), 0);
        chk("rst_a_addr", a_maddr, 0);
        chk("rst_a_gid", 32'(a_gid), 0);
        chk("rst_a_resp", 32'(a_resp), 0);
        chk("rst_b_busy", 32'(b_busy), 0);
        chk("rst_b_be", 32'(b_mbe), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Stray mem_resp in IDLE
        @(negedge clk);
        a_mresp = 1'b1;
        a_mrdata = 32'h0BAD0BAD;
        #1;
        chk("idle_resp", 32'(a_resp), 0);
        chk("idle_rdata", a_rdata, 0);
        @(negedge clk);
        a_mresp = 1'b0;
        chk("idle_busy", 32'(a_busy), 0);

        // Single transactions from the table
        foreach (vecs[i]) begin
            @(negedge clk);
            a_rd = vecs[i].rd;
            a_wr = vecs[i].wr;
            #1;
            chk($sformatf("v%0d_pre", i), 32'(a_mrd | a_mwr), 0);
            @(negedge clk);
            chk($sformatf("v%0d_busy", i), 32'(a_busy), 1);
            chk($sformatf("v%0d_gid", i), 32'(a_gid), vecs[i].gid);
            chk($sformatf("v%0d_mrd", i), 32'(a_mrd), 32'(vecs[i].mrd));
            chk($sformatf("v%0d_mwr", i), 32'(a_mwr), 32'(vecs[i].mwr));
            chk($sformatf("v%0d_addr", i), a_maddr, vecs[i].addr);
            chk($sformatf("v%0d_wdata", i), a_mwd, vecs[i].wdata);
            chk($sformatf("v%0d_be", i), 32'(a_mbe), 32'(vecs[i].be));
            a_rd = '0;
            a_wr = '0;
            @(negedge clk);
            chk($sformatf("v%0d_hold", i), 32'({a_mrd, a_mwr, a_busy}),
                32'({vecs[i].mrd, vecs[i].mwr, 1'b1}));
            chk($sformatf("v%0d_noresp", i), 32'(a_resp), 0);
            @(negedge clk);
            a_mresp = 1'b1;
            a_mrdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_resp", i), 32'(a_resp), 32'(1) << vecs[i].gid);
            chk($sformatf("v%0d_rdata", i), a_rdata, vecs[i].rdata);
            @(negedge clk);
            a_mresp = 1'b0;
            #1;
            chk($sformatf("v%0d_after", i),
                32'({a_busy, a_mrd, a_mwr, a_resp}), 0);
            chk($sformatf("v%0d_rd0", i), a_rdata, 0);
        end

        // Reset in the middle of a transaction
        @(negedge clk);
        a_rd = 2'b01;
        @(negedge clk);
        chk("mid_busy", 32'(a_busy), 1);
        a_rd = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_mrd", 32'(a_mrd), 0);
        chk("mid_busy0", 32'(a_busy), 0);
        chk("mid_resp", 32'(a_resp), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        a_mresp = 1'b1;
        a_mrdata = 32'hFEEDFACE;
        #1;
        chk("post_rst_resp", 32'(a_resp), 0);
        chk("post_rst_rdata", a_rdata, 0);
        @(negedge clk);
        a_mresp = 1'b0;
        chk("post_rst_busy", 32'(a_busy), 0);

        // Round-robin with both channels held: 0,1,0,1, one idle gap each
        a_rd = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_busy", i), 32'(a_busy), 1);
            chk($sformatf("rr%0d_gid", i), 32'(a_gid), 32'(i % 2));
            a_mresp = 1'b1;
            a_mrdata = 32'(i);
            #1;
            chk($sformatf("rr%0d_resp", i), 32'(a_resp), 32'(1) << (i % 2));
            @(negedge clk);
            a_mresp = 1'b0;
            chk($sformatf("rr%0d_gap", i), 32'(a_busy), 0);
            if (i == 3) a_rd = '0;
        end
        @(negedge clk);
        chk("rr_end_busy", 32'(a_busy), 0);

        // Fixed priority instance: ch2 write
        b_wr = 4'b0100;
        @(negedge clk);
        chk("b_mwr", 32'(b_mwr), 1);
        chk("b_mrd", 32'(b_mrd), 0);
        chk("b_addr", b_maddr, 32'h40);
        chk("b_wdata", b_mwd, 32'h12345678);
        chk("b_be", 32'(b_mbe), 32'h3);
        chk("b_gid", 32'(b_gid), 2);
        b_wr = '0;
        @(negedge clk);
        b_mresp = 1'b1;
        b_mrdata = 32'hCAFEF00D;
        #1;
        chk("b_resp", 32'(b_resp), 32'h4);
        chk("b_rdata", b_rdata, 32'hCAFEF00D);
        @(negedge clk);
        b_mresp = 1'b0;
        chk("b_idle", 32'(b_busy), 0);

        // Fixed priority: ch0 starves ch1 until it drops
        b_rd = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("fp%0d_gid", i), 32'(b_gid), (i < 3) ? 0 : 1);
            b_mresp = 1'b1;
            #1;
            chk($sformatf("fp%0d_resp", i), 32'(b_resp),
                (i < 3) ? 32'h1 : 32'h2);
            @(negedge clk);
            b_mresp = 1'b0;
            chk($sformatf("fp%0d_gap", i), 32'(b_busy), 0);
            if (i == 2) b_rd = 4'b0010;
            if (i == 3) b_rd = '0;
        end
        @(negedge clk);
        chk("fp_end_busy", 32'(b_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
